pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter RA_W, default 5, register address width.
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-004 SHALL have parameter LOAD_LAT, default 1, range 1..4, cycles from load in exec to data usable by forwarding.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock; rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have the decode-stage inputs dec_rs1/dec_rs2  in  RA_W  source addresses; dec_rd1/dec_rd2  in  1  source used; dec_mem_write  in  1  decode instr is store.
REQ-007 SHALL have the exec-stage inputs ex_rd, ex_rs2  in  RA_W; ex_reg_write, ex_mem_read, ex_mem_write  in  1.
REQ-008 SHALL have the mem-stage inputs mem_rd  in  RA_W; mem_reg_write, mem_mem_read  in  1.
REQ-009 SHALL have the redirect inputs redirect_valid  in  1; redirect_pc  in  XLEN  taken branch/jump target from exec.
REQ-010 SHALL have the outputs pc  out  XLEN  fetch address; pc_dec  out  XLEN  PC of instr in decode; stall  out  1; valid_dec/valid_ex/valid_mem  out  1  stage-occupied flags.
REQ-011 SHALL have the outputs fwd1_sel/fwd2_sel  out  2  (0 regfile, 1 exec result, 2 mem result); store_fwd  out  1  use mem read data as store data; retired  out  32  retired-instruction count.

Function
REQ-012 Without stall/redirect, pc SHALL advance by 4 per cycle and pc_dec SHALL take the previous pc.
REQ-013 Load-use hazard SHALL be ex_mem_read && valid_ex && ex_rd!=0 && ((dec_rd1 && dec_rs1==ex_rd) || (dec_rd2 && dec_rs2==ex_rd && !dec_mem_write)).
REQ-014 A hazard SHALL assert stall combinationally in the same cycle and keep it for LOAD_LAT cycles total via a down-counter loaded with LOAD_LAT-1.
REQ-015 During stall, pc and pc_dec SHALL hold and valid_ex SHALL be 0 on the next cycle (bubble).
REQ-016 A store whose rs2 matches a load's rd SHALL NOT stall; store_fwd SHALL be 1 when mem_mem_read && ex_mem_write && mem_rd==ex_rs2 && mem_rd!=0.
REQ-017 fwd*_sel SHALL be 1 if the source matches ex_rd with ex_reg_write && valid_ex && !ex_mem_read, else 2 if it matches mem_rd with mem_reg_write && valid_mem, else 0; register 0 SHALL always give 0.
REQ-018 On redirect_valid, pc SHALL load redirect_pc next cycle and valid_dec and valid_ex SHALL be 0 next cycle (two-instruction flush).
REQ-019 Redirect SHALL take priority over stall and SHALL clear the stall counter.
REQ-020 retired SHALL increment by 1 each cycle valid_mem && mem_reg_write is asserted, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-021 While rst is high: pc=RESET_PC, pc_dec=RESET_PC, valid_* =0, stall counter=0, retired=0; stall SHALL be masked to 0.
REQ-022 Reset asserted mid-stall or mid-flush SHALL abort it; the first fetch after release is RESET_PC.

Configuration
REQ-023 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs cycles, stall_cycles and flushes (32 bit, reset 0, wrapping); without it, these ports and counters SHALL be absent and the interface SHALL match REQ-005..011.

Structure
REQ-024 The fwd_sel encoding constants and LOAD_LAT range limits SHALL live in the shared package pipe_pkg.
REQ-025 The hazard/forward compare logic SHALL be one combinational sub-module, hazard_unit; counters and PC/valid registers SHALL stay in pipe_ctrl.

Verification
REQ-026 Reset, then 5 free cycles -> pc = 0,4,8,12,16; stall=0; retired=0.
REQ-027 LOAD_LAT=1: load x5 in exec, decode reads x5 as rs1 -> stall=1 one cycle, valid_ex=0 next, then fwd1_sel=2.
REQ-028 LOAD_LAT=3: same hazard -> stall for exactly 3 cycles, pc constant throughout.
REQ-029 Load x7 in exec, store using x7 as rs2 in decode -> no stall; next cycle store_fwd=1.
REQ-030 redirect_valid with redirect_pc=0x100 during an active stall -> next pc=0x100, valid_dec=valid_ex=0, stall counter 0.
REQ-031 rst asserted in 2nd cycle of a LOAD_LAT=3 stall -> pc=RESET_PC, all valids 0, stall 0 after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: the forwarding-select
// encoding and the supported load-latency range.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;
    localparam int STALL_CNT_W  = $clog2(LOAD_LAT_MAX);

    // Out-of-range latencies are pulled to the nearest supported value so the
    // stall counter can never be loaded with something it cannot hold.
    function automatic int clamp_load_lat(input int lat);
        if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
        if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Purely combinational hazard detection and operand-forwarding selection
// for the decode stage of the pipeline.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] dec_rs1_i,
    input  logic [RA_W-1:0] dec_rs2_i,
    input  logic            dec_rd1_i,
    input  logic            dec_rd2_i,
    input  logic            dec_mem_write_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic [RA_W-1:0] ex_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_mem_write_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            mem_valid_i,
    input  logic            mem_reg_write_i,
    input  logic            mem_mem_read_i,
    output logic            load_use_o,
    output fwd_sel_e        fwd1_sel_o,
    output fwd_sel_e        fwd2_sel_o,
    output logic            store_fwd_o
);

    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic rs1_hit_ex;
    logic rs2_hit_ex;

    // A load in exec has no result yet, so it can only be reached from mem.
    assign ex_fwd_ok  = ex_reg_write_i && ex_valid_i && !ex_mem_read_i;
    assign mem_fwd_ok = mem_reg_write_i && mem_valid_i;

    assign rs1_hit_ex = dec_rd1_i && (dec_rs1_i == ex_rd_i);
    // Store data is patched from the mem stage instead, so it never stalls.
    assign rs2_hit_ex = dec_rd2_i && (dec_rs2_i == ex_rd_i) && !dec_mem_write_i;

    assign load_use_o = ex_mem_read_i && ex_valid_i && (ex_rd_i != '0)
                        && (rs1_hit_ex || rs2_hit_ex);

    assign store_fwd_o = mem_mem_read_i && ex_mem_write_i
                         && (mem_rd_i == ex_rs2_i) && (mem_rd_i != '0);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        fwd1_sel_o = FWD_RF;
        fwd2_sel_o = FWD_RF;
        if (dec_rs1_i != '0) begin
            if (ex_fwd_ok && (dec_rs1_i == ex_rd_i)) begin
                fwd1_sel_o = FWD_EX;
            end else if (mem_fwd_ok && (dec_rs1_i == mem_rd_i)) begin
                fwd1_sel_o = FWD_MEM;
            end
        end
        if (dec_rs2_i != '0) begin
            if (ex_fwd_ok && (dec_rs2_i == ex_rd_i)) begin
                fwd2_sel_o = FWD_EX;
            end else if (mem_fwd_ok && (dec_rs2_i == mem_rd_i)) begin
                fwd2_sel_o = FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: PC sequencing, stage-valid tracking, load-use stalls,
// branch flushes and retirement count. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              RA_W     = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] dec_rs1,
    input  logic [RA_W-1:0] dec_rs2,
    input  logic            dec_rd1,
    input  logic            dec_rd2,
    input  logic            dec_mem_write,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_dec,
    output logic            stall,
    output logic            valid_dec,
    output logic            valid_ex,
    output logic            valid_mem,
    output logic [1:0]      fwd1_sel,
    output logic [1:0]      fwd2_sel,
    output logic            store_fwd,
    output logic [31:0]     retired
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]     cycles,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flushes
`endif
);

    localparam int LAT = clamp_load_lat(LOAD_LAT);
    localparam logic [STALL_CNT_W-1:0] CNT_LOAD = STALL_CNT_W'(LAT - 1);

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        pc_dec_q, pc_dec_d;
    logic                   valid_dec_q, valid_dec_d;
    logic                   valid_ex_q, valid_ex_d;
    logic                   valid_mem_q, valid_mem_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]            retired_q, retired_d;

    logic     load_use;
    logic     stall_busy;
    fwd_sel_e fwd1_w;
    fwd_sel_e fwd2_w;

    hazard_unit #(
        .RA_W (RA_W)
    ) u_hazard (
        .dec_rs1_i       (dec_rs1),
        .dec_rs2_i       (dec_rs2),
        .dec_rd1_i       (dec_rd1),
        .dec_rd2_i       (dec_rd2),
        .dec_mem_write_i (dec_mem_write),
        .ex_rd_i         (ex_rd),
        .ex_rs2_i        (ex_rs2),
        .ex_valid_i      (valid_ex_q),
        .ex_reg_write_i  (ex_reg_write),
        .ex_mem_read_i   (ex_mem_read),
        .ex_mem_write_i  (ex_mem_write),
        .mem_rd_i        (mem_rd),
        .mem_valid_i     (valid_mem_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_mem_read_i  (mem_mem_read),
        .load_use_o      (load_use),
        .fwd1_sel_o      (fwd1_w),
        .fwd2_sel_o      (fwd2_w),
        .store_fwd_o     (store_fwd)
    );

    // The hazard cycle itself is the first stall cycle; the counter covers the rest.
    assign stall_busy = (stall_cnt_q != '0);
    assign stall      = !rst && (load_use || stall_busy);

    always_comb begin
        pc_d        = pc_q;
        pc_dec_d    = pc_dec_q;
        valid_dec_d = valid_dec_q;
        valid_ex_d  = valid_ex_q;
        valid_mem_d = valid_ex_q;
        stall_cnt_d = stall_cnt_q;
        retired_d   = retired_q + {31'b0, (valid_mem_q && mem_reg_write)};

        if (redirect_valid) begin
            // Squash the two younger instructions and abandon any stall.
            pc_d        = redirect_pc;
            pc_dec_d    = pc_q;
            valid_dec_d = 1'b0;
            valid_ex_d  = 1'b0;
            stall_cnt_d = '0;
        end else if (stall) begin
            valid_ex_d  = 1'b0;
            stall_cnt_d = stall_busy ? (stall_cnt_q - 1'b1) : CNT_LOAD;
        end else begin
            pc_d        = pc_q + XLEN'(4);
            pc_dec_d    = pc_q;
            valid_dec_d = 1'b1;
            valid_ex_d  = valid_dec_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pc_dec_q    <= RESET_PC;
            valid_dec_q <= 1'b0;
            valid_ex_q  <= 1'b0;
            valid_mem_q <= 1'b0;
            stall_cnt_q <= '0;
            retired_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            pc_dec_q    <= pc_dec_d;
            valid_dec_q <= valid_dec_d;
            valid_ex_q  <= valid_ex_d;
            valid_mem_q <= valid_mem_d;
            stall_cnt_q <= stall_cnt_d;
            retired_q   <= retired_d;
        end
    end

    assign pc        = pc_q;
    assign pc_dec    = pc_dec_q;
    assign valid_dec = valid_dec_q;
    assign valid_ex  = valid_ex_q;
    assign valid_mem = valid_mem_q;
    assign fwd1_sel  = fwd1_w;
    assign fwd2_sel  = fwd2_w;
    assign retired   = retired_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cycles_q;
    logic [31:0] stall_cycles_q;
    logic [31:0] flushes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q       <= '0;
            stall_cycles_q <= '0;
            flushes_q      <= '0;
        end else begin
            cycles_q       <= cycles_q + 32'd1;
            stall_cycles_q <= stall_cycles_q + {31'b0, stall};
            flushes_q      <= flushes_q + {31'b0, redirect_valid};
        end
    end

    assign cycles       = cycles_q;
    assign stall_cycles = stall_cycles_q;
    assign flushes      = flushes_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (LOAD_LAT 1 and 3) share stimulus and are
// compared every cycle against a cycle-indexed behavioural model.
module tb_pipe_ctrl;

    localparam int          XLEN   = 32;
    localparam int          RA_W   = 5;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          LATS [2] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [RA_W-1:0] dec_rs1, dec_rs2, ex_rd, ex_rs2, mem_rd;
    logic            dec_rd1, dec_rd2, dec_mem_write;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic            mem_reg_write, mem_mem_read;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic [XLEN-1:0] o_pc [2];
    logic [XLEN-1:0] o_pc_dec [2];
    logic            o_stall [2];
    logic            o_vd [2];
    logic            o_ve [2];
    logic            o_vm [2];
    logic [1:0]      o_fwd1 [2];
    logic [1:0]      o_fwd2 [2];
    logic            o_sfwd [2];
    logic [31:0]     o_ret [2];
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]     o_cyc [2];
    logic [31:0]     o_scyc [2];
    logic [31:0]     o_fl [2];
`endif

    pipe_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .RESET_PC(RST_PC), .LOAD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd1(dec_rd1), .dec_rd2(dec_rd2),
        .dec_mem_write(dec_mem_write),
        .ex_rd(ex_rd), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(o_pc[0]), .pc_dec(o_pc_dec[0]), .stall(o_stall[0]),
        .valid_dec(o_vd[0]), .valid_ex(o_ve[0]), .valid_mem(o_vm[0]),
        .fwd1_sel(o_fwd1[0]), .fwd2_sel(o_fwd2[0]), .store_fwd(o_sfwd[0]),
        .retired(o_ret[0])
`ifdef PIPE_CTRL_PERF_EN
        , .cycles(o_cyc[0]), .stall_cycles(o_scyc[0]), .flushes(o_fl[0])
`endif
    );

    pipe_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .RESET_PC(RST_PC), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd1(dec_rd1), .dec_rd2(dec_rd2),
        .dec_mem_write(dec_mem_write),
        .ex_rd(ex_rd), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(o_pc[1]), .pc_dec(o_pc_dec[1]), .stall(o_stall[1]),
        .valid_dec(o_vd[1]), .valid_ex(o_ve[1]), .valid_mem(o_vm[1]),
        .fwd1_sel(o_fwd1[1]), .fwd2_sel(o_fwd2[1]), .store_fwd(o_sfwd[1]),
        .retired(o_ret[1])
`ifdef PIPE_CTRL_PERF_EN
        , .cycles(o_cyc[1]), .stall_cycles(o_scyc[1]), .flushes(o_fl[1])
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a stall is an episode that covers cycles
    // [start, start+LAT); a redirect or reset cancels the episode.
    logic [31:0] m_pc [2];
    logic [31:0] m_pc_dec [2];
    bit          m_vd [2];
    bit          m_ve [2];
    bit          m_vm [2];
    int          m_stall_until [2];
    logic [31:0] m_ret [2];
    int          cyc   = 0;
    bit          known = 1'b0;

    function automatic bit m_hazard(int k);
        return ex_mem_read && m_ve[k] && (ex_rd != 0) &&
               ((dec_rd1 && dec_rs1 == ex_rd) ||
                (dec_rd2 && dec_rs2 == ex_rd && !dec_mem_write));
    endfunction

    function automatic bit m_stall(int k);
        return !rst && (m_hazard(k) || (cyc < m_stall_until[k]));
    endfunction

    function automatic logic [1:0] m_fwd(int k, logic [RA_W-1:0] src);
        if (src == 0) return 2'd0;
        if (src == ex_rd && ex_reg_write && m_ve[k] && !ex_mem_read) return 2'd1;
        if (src == mem_rd && mem_reg_write && m_vm[k]) return 2'd2;
        return 2'd0;
    endfunction

    task automatic settle();
        #1;
        if (known) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("pc[%0d]", k), o_pc[k], m_pc[k]);
                check($sformatf("pc_dec[%0d]", k), o_pc_dec[k], m_pc_dec[k]);
                check($sformatf("valid_dec[%0d]", k), o_vd[k], m_vd[k]);
                check($sformatf("valid_ex[%0d]", k), o_ve[k], m_ve[k]);
                check($sformatf("valid_mem[%0d]", k), o_vm[k], m_vm[k]);
                check($sformatf("stall[%0d]", k), o_stall[k], m_stall(k));
                check($sformatf("fwd1[%0d]", k), o_fwd1[k], m_fwd(k, dec_rs1));
                check($sformatf("fwd2[%0d]", k), o_fwd2[k], m_fwd(k, dec_rs2));
                check($sformatf("store_fwd[%0d]", k), o_sfwd[k],
                      mem_mem_read && ex_mem_write && mem_rd == ex_rs2 && mem_rd != 0);
                check($sformatf("retired[%0d]", k), o_ret[k], m_ret[k]);
            end
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            bit hz     = m_hazard(k);
            bit active = cyc < m_stall_until[k];
            bit old_ve = m_ve[k];
            if (rst) begin
                m_pc[k] = RST_PC;  m_pc_dec[k] = RST_PC;
                m_vd[k] = 0;  m_ve[k] = 0;  m_vm[k] = 0;
                m_stall_until[k] = 0;  m_ret[k] = 0;
            end else begin
                if (m_vm[k] && mem_reg_write) m_ret[k] = m_ret[k] + 32'd1;
                if (redirect_valid) begin
                    m_pc_dec[k] = m_pc[k];
                    m_pc[k] = redirect_pc;
                    m_vd[k] = 0;  m_ve[k] = 0;
                    m_stall_until[k] = 0;
                end else if (hz || active) begin
                    m_ve[k] = 0;
                    if (!active) m_stall_until[k] = cyc + LATS[k];
                end else begin
                    m_pc_dec[k] = m_pc[k];
                    m_pc[k] = m_pc[k] + 32'd4;
                    m_ve[k] = m_vd[k];
                    m_vd[k] = 1;
                end
                m_vm[k] = old_ve;
            end
        end
        if (rst) known = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        dec_rs1 = '0; dec_rs2 = '0; dec_rd1 = 0; dec_rd2 = 0; dec_mem_write = 0;
        ex_rd = '0; ex_rs2 = '0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        mem_rd = '0; mem_reg_write = 0; mem_mem_read = 0;
        redirect_valid = 0; redirect_pc = '0;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic load_use_x5();
        idle_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5;
        dec_rd1 = 1; dec_rs1 = 5'd5;
    endtask

    logic [31:0] pc_hold;

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            settle();
            advance();
        end

        // Free-running fetch after reset.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("free_pc", o_pc[0], 32'(i * 4));
            check("free_stall", o_stall[1], 1'b0);
            check("free_retired", o_ret[0], 32'd0);
            advance();
        end

        // Load-use on x5: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 three.
        load_use_x5();
        settle();
        check("lu_stall1", o_stall[0], 1'b1);
        check("lu_stall3", o_stall[1], 1'b1);
        pc_hold = o_pc[1];
        advance();
        for (int j = 1; j <= 3; j++) begin
            idle_inputs();
            dec_rd1 = 1; dec_rs1 = 5'd5;
            if (j == 1) begin
                mem_rd = 5'd5; mem_reg_write = 1; mem_mem_read = 1;
            end
            settle();
            if (j == 1) begin
                check("lu1_stall_off", o_stall[0], 1'b0);
                check("lu1_bubble", o_ve[0], 1'b0);
                check("lu1_fwd_mem", o_fwd1[0], 2'd2);
            end
            check("lu3_stall", o_stall[1], j < 3);
            check("lu3_pc_hold", o_pc[1], pc_hold);
            advance();
        end
        idle_cycles(3);

        // Store whose rs2 is the loaded register: no stall, then store_fwd.
        idle_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd7;
        dec_rd1 = 1; dec_rs1 = 5'd3; dec_rd2 = 1; dec_rs2 = 5'd7; dec_mem_write = 1;
        settle();
        check("st_nostall1", o_stall[0], 1'b0);
        check("st_nostall3", o_stall[1], 1'b0);
        advance();
        idle_inputs();
        mem_rd = 5'd7; mem_reg_write = 1; mem_mem_read = 1;
        ex_mem_write = 1; ex_rs2 = 5'd7;
        settle();
        check("st_fwd", o_sfwd[0], 1'b1);
        advance();
        idle_cycles(2);

        // Redirect in the middle of a LOAD_LAT=3 stall.
        load_use_x5();
        settle();
        advance();
        idle_inputs();
        redirect_valid = 1; redirect_pc = 32'h100;
        settle();
        check("rd_mid_stall", o_stall[1], 1'b1);
        advance();
        idle_inputs();
        settle();
        check("rd_pc", o_pc[1], 32'h100);
        check("rd_vd", o_vd[1], 1'b0);
        check("rd_ve", o_ve[1], 1'b0);
        check("rd_stall", o_stall[1], 1'b0);
        advance();
        idle_cycles(3);

        // Reset in the second cycle of a LOAD_LAT=3 stall.
        load_use_x5();
        settle();
        advance();
        idle_inputs();
        rst = 1'b1;
        settle();
        check("rst_mask", o_stall[1], 1'b0);
        advance();
        rst = 1'b0;
        settle();
        check("rst_pc", o_pc[1], RST_PC);
        check("rst_vd", o_vd[1], 1'b0);
        check("rst_ve", o_ve[1], 1'b0);
        check("rst_vm", o_vm[1], 1'b0);
        check("rst_stall", o_stall[1], 1'b0);
        advance();

        // Randomised traffic over a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            dec_rs1        = RA_W'($urandom_range(0, 3));
            dec_rs2        = RA_W'($urandom_range(0, 3));
            dec_rd1        = 1'($urandom_range(0, 1));
            dec_rd2        = 1'($urandom_range(0, 1));
            dec_mem_write  = ($urandom_range(0, 3) == 0);
            ex_rd          = RA_W'($urandom_range(0, 3));
            ex_rs2         = RA_W'($urandom_range(0, 3));
            ex_reg_write   = 1'($urandom_range(0, 1));
            ex_mem_read    = ($urandom_range(0, 2) == 0);
            ex_mem_write   = ($urandom_range(0, 3) == 0);
            mem_rd         = RA_W'($urandom_range(0, 3));
            mem_reg_write  = 1'($urandom_range(0, 1));
            mem_mem_read   = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
